// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake, a persistent ZCNV flags register
// and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic [4:0]       uop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err,
  output logic             busy
);

  localparam logic [4:0] U_ADD = 5'b00001;
  localparam logic [4:0] U_SUB = 5'b00010;
  localparam logic [4:0] U_AND = 5'b00011;
  localparam logic [4:0] U_XOR = 5'b00100;
  localparam logic [4:0] U_CMP = 5'b00101;
  localparam logic [4:0] U_LSL = 5'b00110;
  localparam logic [4:0] U_LSR = 5'b00111;
  localparam logic [4:0] U_MOV = 5'b01000;
  localparam logic [4:0] U_ADC = 5'b01001;
  localparam logic [4:0] U_ASR = 5'b01010;
  localparam logic [4:0] U_MUL = 5'b01011;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [3:0]        flags_q, flags_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      addb;
  logic                  cin;
  logic                  ovf;
  logic [7:0]            amt;
  logic [WIDTH:0]        lsl_ext;
  logic [WIDTH:0]        lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]      res;
  logic                  c_new;
  logic                  v_new;
  logic                  ill;
  logic [3:0]            alu_flags;
  logic                  is_mul;
  logic [WIDTH-1:0]      prod;

  assign is_mul = MUL_EN && (uop == U_MUL);
  assign amt    = RHS[7:0];

  // Subtraction is LHS + ~RHS + 1 so C reads as no-borrow
  always_comb begin
    addb = RHS;
    cin  = 1'b0;
    if (uop == U_SUB || uop == U_CMP) begin
      addb = ~RHS;
      cin  = 1'b1;
    end else if (uop == U_ADC) begin
      cin = flags_q[2];
    end
    sum = {1'b0, LHS} + {1'b0, addb} + {{WIDTH{1'b0}}, cin};
  end

  assign ovf = (LHS[WIDTH-1] == addb[WIDTH-1]) &
               (sum[WIDTH-1] != LHS[WIDTH-1]);

  // One spare bit on each shift catches the last bit shifted out
  assign lsl_ext = {1'b0, LHS} << amt;
  assign lsr_ext = {LHS, 1'b0} >> amt;
  assign asr_ext = $signed({LHS, 1'b0}) >>> amt;

  always_comb begin
    res   = '0;
    c_new = flags_q[2];
    v_new = flags_q[0];
    ill   = 1'b0;
    unique case (uop)
      U_ADD, U_SUB, U_CMP, U_ADC: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = ovf;
      end
      U_AND: res = LHS & RHS;
      U_XOR: res = LHS ^ RHS;
      U_MOV: res = RHS;
      U_LSL: begin
        res = lsl_ext[WIDTH-1:0];
        if (amt != 8'd0) c_new = lsl_ext[WIDTH];
      end
      U_LSR: begin
        res = lsr_ext[WIDTH:1];
        if (amt != 8'd0) c_new = lsr_ext[0];
      end
      U_ASR: begin
        res = asr_ext[WIDTH:1];
        if (amt != 8'd0) c_new = asr_ext[0];
      end
      default: ill = 1'b1;
    endcase
    if (ill) alu_flags = flags_q;
    else     alu_flags = {res == '0, c_new, res[WIDTH-1], v_new};
  end

  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready  = (state_q == S_IDLE) |
                     ((state_q == S_RESULT) & out_ready);
  assign out_valid = (state_q == S_RESULT);
  assign busy      = (state_q == S_BUSY);
  assign out       = out_q;
  assign flags     = flags_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    flags_d  = flags_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_BUSY: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_RESULT;
          out_d   = prod;
          err_d   = 1'b0;
          flags_d = {prod == '0, flags_q[2], prod[WIDTH-1], flags_q[0]};
        end
      end
      default: begin
        if (state_q == S_RESULT && out_ready) state_d = S_IDLE;
        if (in_valid && in_ready) begin
          if (is_mul) begin
            state_d  = S_BUSY;
            acc_d    = '0;
            mcand_d  = LHS;
            mplier_d = RHS;
            cnt_d    = '0;
          end else begin
            state_d = S_RESULT;
            out_d   = res;
            flags_d = alu_flags;
            err_d   = ill;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=32.
module tb_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  uop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [3:0]  flags;
  logic        err;
  logic        busy;

  int vectors;
  int miscompares;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .LHS(lhs),
    .RHS(rhs),
    .uop(uop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out_w),
    .flags(flags),
    .err(err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one op; returns #1 after the accepting edge
  task automatic op(input logic [4:0] u, input logic [31:0] a,
                    input logic [31:0] b);
    int n;
    @(negedge clk);
    uop = u;
    lhs = a;
    rhs = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic run(input string tag, input logic [4:0] u,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eo, input logic [3:0] ef,
                     input logic ee);
    op(u, a, b);
    wait_res();
    chk({tag, "_out"}, out_w, eo);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    chk({tag, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lhs = '0;
    rhs = '0;
    uop = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out_w, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run("add_ovf", 5'b00001, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0011, 1'b0);
    run("sub_eq", 5'b00010, 32'h1, 32'h1, 32'h0, 4'b1100, 1'b0);
    run("cmp", 5'b00101, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0011, 1'b0);
    run("sub_eq2", 5'b00010, 32'h1, 32'h1, 32'h0, 4'b1100, 1'b0);
    run("adc", 5'b01001, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b1100, 1'b0);
    run("and", 5'b00011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 4'b1100, 1'b0);
    run("lsr32", 5'b00111, 32'h80000000, 32'd32, 32'h0, 4'b1100, 1'b0);
    run("asr4", 5'b01010, 32'h80000000, 32'd4, 32'hF8000000, 4'b0010, 1'b0);
    run("lsl0", 5'b00110, 32'h1, 32'd0, 32'h1, 4'b0000, 1'b0);
    run("lsl1", 5'b00110, 32'h80000001, 32'd1, 32'h2, 4'b0100, 1'b0);
    run("lsl40", 5'b00110, 32'h1, 32'd40, 32'h0, 4'b1000, 1'b0);
    run("asr40", 5'b01010, 32'h80000000, 32'd40, 32'hFFFFFFFF, 4'b0110, 1'b0);

    op(5'b01011, 32'h10000, 32'h10000);
    chk("mul_in_ready", 32'(in_ready), 32'd0);
    lhs = 32'h12345678;
    rhs = 32'h9ABCDEF0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_busy_cycles", 32'(n), 32'd32);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_out", out_w, 32'h0);
    chk("mul_flags", 32'(flags), 32'(4'b1100));

    run("mul76", 5'b01011, 32'd7, 32'd6, 32'd42, 4'b0100, 1'b0);

    op(5'b01011, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mulrst_busy", 32'(busy), 32'd0);
    chk("mulrst_flags", 32'(flags), 32'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("mulrst_no_valid", 32'(n), 32'd0);

    out_ready = 1'b0;
    op(5'b00100, 32'hAAAAAAAA, 32'h55555555);
    chk("xor_out", out_w, 32'hFFFFFFFF);
    chk("xor_flags", 32'(flags), 32'(4'b0010));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out", out_w, 32'hFFFFFFFF);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    run("add_same_edge", 5'b00001, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0);

    run("sub_pre_ill", 5'b00010, 32'h1, 32'h1, 32'h0, 4'b1100, 1'b0);
    run("ill_1f", 5'b11111, 32'h1234, 32'h5678, 32'h0, 4'b1100, 1'b1);
    run("ill_00", 5'b00000, 32'h1, 32'h1, 32'h0, 4'b1100, 1'b1);
    run("add_after_ill", 5'b00001, 32'h1, 32'h1, 32'h2, 4'b0000, 1'b0);
    run("mov", 5'b01000, 32'h0, 32'h80000000, 32'h80000000, 4'b0010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
